// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 has priority, and a streak limit stops port 1 from starving.
// Latency: grant and memory controls are combinational; read data returns the cycle after its grant.
// Backpressure: a requester holds its request until gnt; a losing request waits, and a dropped one is not served.
module dmem_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_be,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_be,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,

    output logic              mem_write,
    output logic [3:0]        byte_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [ADDR_W-1:0] read_addr,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0] streak;
    logic       streak_hit;
    logic       rd_pend;
    logic       rd_owner;
    logic       any_gnt;
    logic       win_we;
    logic       rd_issue;

    // Port 1 wins only when it asks alone or port 0 has used up its streak.
    always_comb begin
        streak_hit = (streak >= STREAK_MAX);
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        if (!rst) begin
            p1_gnt = p1_req && (!p0_req || streak_hit);
            p0_gnt = p0_req && !p1_gnt;
        end
    end

    always_comb begin
        any_gnt    = p0_gnt | p1_gnt;
        write_addr = p1_gnt ? p1_addr  : p0_addr;
        read_addr  = p1_gnt ? p1_addr  : p0_addr;
        write_data = p1_gnt ? p1_wdata : p0_wdata;
        win_we     = p1_gnt ? p1_we    : p0_we;
        mem_write  = any_gnt & win_we;
        byte_en    = mem_write ? (p1_gnt ? p1_be : p0_be) : 4'b0000;
        rd_issue   = any_gnt & ~win_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak   <= 4'd0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (p0_gnt && p1_req)
                streak <= streak_hit ? STREAK_MAX : streak + 4'd1;
            else
                streak <= 4'd0;
            rd_pend <= rd_issue;
            if (rd_issue)
                rd_owner <= p1_gnt;
        end
    end

    // Read data fans out to both ports unqualified; rvalid tells the owner it is theirs.
    assign p0_rvalid = rd_pend & ~rd_owner;
    assign p1_rvalid = rd_pend &  rd_owner;
    assign p0_rdata  = read_data;
    assign p1_rdata  = read_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: external memory, directed scenarios, and randomized traffic
// against a transaction-level model of grants, memory contents and read returns.
module tb_dmem_arbiter;
    localparam int ADDR_W     = 18;
    localparam int MAX_STREAK = 4;
    localparam int DEPTH      = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic [3:0]        p0_be, p1_be;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_write;
    logic [3:0]        byte_en;
    logic [ADDR_W-1:0] write_addr, read_addr;
    logic [31:0]       write_data;
    logic [31:0]       read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_write(mem_write), .byte_en(byte_en), .write_addr(write_addr), .read_addr(read_addr),
        .write_data(write_data), .read_data(read_data)
    );

    // Physical memory: byte-enabled synchronous write, 1-cycle synchronous read.
    logic [31:0] phys [DEPTH] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_write)
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) phys[write_addr][8*b +: 8] <= write_data[8*b +: 8];
    end
    always @(posedge clk) read_data <= phys[read_addr];

    // Reference model state
    logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
    int          m_run;        // consecutive port-0 wins while port 1 has been waiting
    int          m_pend;       // 0 none, 1 port 0, 2 port 1
    logic [31:0] m_pend_data;
    int          n_cmp, n_err;

    logic              e_g0, e_g1, e_rv0, e_rv1;
    logic [31:0]       e_rdata;
    logic              o_g0, o_g1, o_mw, o_rv0, o_rv1;
    logic [3:0]        o_be;
    logic [ADDR_W-1:0] o_waddr, o_raddr;
    logic [31:0]       o_wdata, o_rd0, o_rd1;

    task automatic set_p0(input logic r, input logic w, input int a, input logic [31:0] d, input logic [3:0] b);
        p0_req = r; p0_we = w; p0_addr = ADDR_W'(a); p0_wdata = d; p0_be = b;
    endtask

    task automatic set_p1(input logic r, input logic w, input int a, input logic [31:0] d, input logic [3:0] b);
        p1_req = r; p1_we = w; p1_addr = ADDR_W'(a); p1_wdata = d; p1_be = b;
    endtask

    task automatic idle();
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    // One clock: sample DUT and model expectations mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d, mask;
        logic [3:0]        b;
        @(negedge clk);
        e_g1  = !rst && p1_req && (!p0_req || m_run == MAX_STREAK);
        e_g0  = !rst && p0_req && !e_g1;
        e_rv0 = (m_pend == 1);
        e_rv1 = (m_pend == 2);
        e_rdata = m_pend_data;
        o_g0 = p0_gnt; o_g1 = p1_gnt; o_mw = mem_write; o_be = byte_en;
        o_waddr = write_addr; o_raddr = read_addr; o_wdata = write_data;
        o_rv0 = p0_rvalid; o_rv1 = p1_rvalid; o_rd0 = p0_rdata; o_rd1 = p1_rdata;
        @(posedge clk);
        m_pend = 0;
        if (rst) begin
            m_run = 0;
        end else begin
            m_run = (e_g0 && p1_req) ? ((m_run < MAX_STREAK) ? m_run + 1 : MAX_STREAK) : 0;
            if (e_g0 || e_g1) begin
                w = e_g1 ? p1_we : p0_we;
                a = e_g1 ? p1_addr : p0_addr;
                d = e_g1 ? p1_wdata : p0_wdata;
                b = e_g1 ? p1_be : p0_be;
                if (w) begin
                    mask = 32'h0;
                    for (int i = 0; i < 4; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
                    ref_mem[a] = (ref_mem[a] & ~mask) | (d & mask);
                end else begin
                    m_pend      = e_g1 ? 2 : 1;
                    m_pend_data = ref_mem[a];
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_p0(1'b1, 1'b1, 5, 32'hFFFF_FFFF, 4'hF);
        set_p1(1'b1, 1'b1, 6, 32'hFFFF_FFFF, 4'hF);
        tick();
        n_cmp++; if (o_g0 !== 1'b0 || o_g1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b%b want 00", o_g0, o_g1); end
        n_cmp++; if (o_mw !== 1'b0 || o_be !== 4'h0) begin n_err++; $display("FAIL rst_memctl: got mw=%b be=%h want 0/0", o_mw, o_be); end
        n_cmp++; if (o_rv0 !== 1'b0 || o_rv1 !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b%b want 00", o_rv0, o_rv1); end
        rst = 1'b0; idle();
        tick();
    endtask

    task automatic test_p0_write_read();
        set_p0(1'b1, 1'b1, 'h10, 32'hDEAD_BEEF, 4'hF);
        tick();
        n_cmp++; if (o_g0 !== 1'b1 || o_g1 !== 1'b0) begin n_err++; $display("FAIL p0wr_gnt: got %b%b want 10", o_g0, o_g1); end
        n_cmp++; if (o_mw !== 1'b1 || o_be !== 4'hF || o_waddr !== ADDR_W'('h10) || o_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL p0wr_drive: got mw=%b be=%h a=%h d=%h want 1/f/10/deadbeef", o_mw, o_be, o_waddr, o_wdata); end
        set_p0(1'b1, 1'b0, 'h10, 32'h0, 4'h0);
        tick();
        n_cmp++; if (o_g0 !== 1'b1 || o_mw !== 1'b0 || o_raddr !== ADDR_W'('h10)) begin
            n_err++; $display("FAIL p0rd_issue: got g=%b mw=%b a=%h want 1/0/10", o_g0, o_mw, o_raddr); end
        idle();
        tick();
        n_cmp++; if (o_rv0 !== 1'b1 || o_rv1 !== 1'b0 || o_rd0 !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL p0rd_data: got rv=%b%b d=%h want 10/deadbeef", o_rv0, o_rv1, o_rd0); end
        tick();
        n_cmp++; if (o_rv0 !== 1'b0) begin n_err++; $display("FAIL p0rd_onepulse: got %b want 0", o_rv0); end
    endtask

    task automatic test_p1_partial_write();
        set_p1(1'b1, 1'b1, 'h20, 32'h1122_3344, 4'b0101);
        tick();
        n_cmp++; if (o_g1 !== 1'b1 || o_be !== 4'b0101) begin n_err++; $display("FAIL p1wr: got g=%b be=%h want 1/5", o_g1, o_be); end
        set_p1(1'b1, 1'b0, 'h20, 32'h0, 4'h0);
        tick();
        idle();
        tick();
        n_cmp++; if (o_rv1 !== 1'b1 || o_rv0 !== 1'b0 || o_rd1 !== 32'h0022_0044) begin
            n_err++; $display("FAIL p1rd_partial: got rv=%b%b d=%h want 01/00220044", o_rv0, o_rv1, o_rd1); end
    endtask

    task automatic test_streak();
        logic [9:0] pat;
        pat = 10'b10_0001_0000;
        tick();
        set_p1(1'b1, 1'b0, 'h50, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            set_p0(1'b1, 1'b0, 'h40 + i, 32'h0, 4'h0);
            tick();
            n_cmp++; if (o_g1 !== pat[i] || o_g0 !== !pat[i]) begin
                n_err++; $display("FAIL streak_gnt[%0d]: got %b%b want p1=%b", i, o_g0, o_g1, pat[i]); end
            if (i > 0) begin
                n_cmp++; if (o_rv1 !== pat[i-1] || o_rv0 !== !pat[i-1]) begin
                    n_err++; $display("FAIL streak_rv[%0d]: got %b%b want p1=%b", i, o_rv0, o_rv1, pat[i-1]); end
            end
        end
        idle();
        tick();
        n_cmp++; if (o_rv1 !== 1'b1 || o_rv0 !== 1'b0) begin n_err++; $display("FAIL streak_lastrv: got %b%b want 01", o_rv0, o_rv1); end
    endtask

    task automatic test_back_to_back();
        set_p0(1'b1, 1'b1, 'h1, 32'hA1A1_0101, 4'hF); tick();
        set_p0(1'b1, 1'b1, 'h2, 32'hB2B2_0202, 4'hF); tick();
        set_p0(1'b1, 1'b0, 'h1, 32'h0, 4'h0); tick();
        idle();
        set_p1(1'b1, 1'b0, 'h2, 32'h0, 4'h0); tick();
        n_cmp++; if (o_rv0 !== 1'b1 || o_rd0 !== 32'hA1A1_0101 || o_g1 !== 1'b1) begin
            n_err++; $display("FAIL b2b_p0: got rv=%b d=%h g1=%b want 1/a1a10101/1", o_rv0, o_rd0, o_g1); end
        idle(); tick();
        n_cmp++; if (o_rv1 !== 1'b1 || o_rv0 !== 1'b0 || o_rd1 !== 32'hB2B2_0202) begin
            n_err++; $display("FAIL b2b_p1: got rv=%b%b d=%h want 01/b2b20202", o_rv0, o_rv1, o_rd1); end
    endtask

    task automatic test_reset_mid_read();
        tick();
        set_p0(1'b1, 1'b0, 'h60, 32'h0, 4'h0);
        set_p1(1'b1, 1'b0, 'h61, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (o_g0 !== 1'b1) begin n_err++; $display("FAIL mid_pre: got g0=%b want 1", o_g0); end
        rst = 1'b1;
        tick();
        n_cmp++; if (o_g0 !== 1'b0 || o_g1 !== 1'b0 || o_mw !== 1'b0) begin
            n_err++; $display("FAIL mid_rstgnt: got g=%b%b mw=%b want 00/0", o_g0, o_g1, o_mw); end
        n_cmp++; if (o_rv0 !== 1'b1) begin n_err++; $display("FAIL mid_rvcycle: got %b want 1", o_rv0); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                n_cmp++; if (o_rv0 !== 1'b0 || o_rv1 !== 1'b0) begin n_err++; $display("FAIL mid_discard: got %b%b want 00", o_rv0, o_rv1); end
            end
            n_cmp++; if (o_g1 !== (i == 4)) begin n_err++; $display("FAIL mid_streak[%0d]: got g1=%b want %b", i, o_g1, i == 4); end
        end
        idle(); tick();
    endtask

    task automatic test_zero_be();
        set_p0(1'b1, 1'b1, 'h30, 32'h55AA_55AA, 4'hF); tick();
        set_p0(1'b1, 1'b1, 'h30, 32'hFFFF_FFFF, 4'h0); tick();
        n_cmp++; if (o_g0 !== 1'b1 || o_mw !== 1'b1 || o_be !== 4'h0) begin
            n_err++; $display("FAIL zbe_drive: got g=%b mw=%b be=%h want 1/1/0", o_g0, o_mw, o_be); end
        set_p0(1'b1, 1'b0, 'h30, 32'h0, 4'h0); tick();
        idle(); tick();
        n_cmp++; if (o_rv0 !== 1'b1 || o_rd0 !== 32'h55AA_55AA) begin
            n_err++; $display("FAIL zbe_read: got rv=%b d=%h want 1/55aa55aa", o_rv0, o_rd0); end
    endtask

    task automatic test_random();
        logic       e_mw;
        logic [3:0] e_be;
        tick();
        for (int i = 0; i < 400; i++) begin
            if (!p0_req || e_g0)
                set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom, 4'($urandom));
            if (!p1_req || e_g1)
                set_p1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom, 4'($urandom));
            tick();
            e_mw = (e_g0 && p0_we) || (e_g1 && p1_we);
            e_be = e_mw ? (e_g1 ? p1_be : p0_be) : 4'h0;
            n_cmp++; if (o_g0 !== e_g0 || o_g1 !== e_g1) begin
                n_err++; $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b", i, o_g0, o_g1, e_g0, e_g1); end
            n_cmp++; if (o_mw !== e_mw || o_be !== e_be) begin
                n_err++; $display("FAIL rnd_memctl[%0d]: got mw=%b be=%h want %b/%h", i, o_mw, o_be, e_mw, e_be); end
            n_cmp++; if (o_rv0 !== e_rv0 || o_rv1 !== e_rv1) begin
                n_err++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", i, o_rv0, o_rv1, e_rv0, e_rv1); end
            if (e_rv0 || e_rv1) begin
                n_cmp++; if ((e_rv0 ? o_rd0 : o_rd1) !== e_rdata) begin
                    n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, e_rv0 ? o_rd0 : o_rd1, e_rdata); end
            end
        end
        idle(); tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; m_run = 0; m_pend = 0; m_pend_data = 32'h0;
        rst = 1'b1;
        set_p0(1'b0, 1'b0, 0, 32'h0, 4'h0);
        set_p1(1'b0, 1'b0, 0, 32'h0, 4'h0);
        @(posedge clk); #1;
        test_reset();
        test_p0_write_read();
        test_p1_partial_write();
        test_streak();
        test_back_to_back();
        test_reset_mid_read();
        test_zero_be();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
